// File: rtl/decoder_e_md.sv
// EX-stage control: D/E instruction register, registered ALU decode and a multiply/divide
// issue sequencer with hi/lo hazard stall toward D. Optional md_cancel input via MD_CANCEL_EN.
module decoder_e_md #(
  parameter int unsigned OP_W        = 5,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
`ifdef MD_CANCEL_EN
  input  logic              md_cancel_i,
`endif
  input  logic [31:0]       instr_d_i,
  input  logic              bubble_e_i,
  output logic              alu_src_o,
  output logic [1:0]        reg_dst_o,
  output logic [OP_W-1:0]   operator_o,
  output logic [31:0]       instr_e_o,
  output logic              md_start_o,
  output logic [1:0]        md_op_o,
  output logic              md_busy_o,
  output logic              md_done_o,
  output logic              hi_we_o,
  output logic              lo_we_o,
  output logic              stall_d_o
);

  localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StBusy} md_state_e;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic [1:0]       md_op_q, md_op_d;
  logic             done_q, done_d;

  logic [31:0]      instr_e_q;
  logic             alu_src_q, hi_we_q, lo_we_q;
  logic [1:0]       reg_dst_q;
  logic [4:0]       op_q;

  logic [4:0]       op_dec;
  logic [1:0]       reg_dst_dec;
  logic             alu_src_dec, md_class_dec, muldiv_dec, hi_dec, lo_dec;
  logic             load_bubble, issue, cancel, busy;

`ifdef MD_CANCEL_EN
  assign cancel = md_cancel_i;
`else
  assign cancel = 1'b0;
`endif

  // Decode of the instruction in D; registered into E below.
  always_comb begin
    op_dec       = 5'd0;
    reg_dst_dec  = 2'b00;
    alu_src_dec  = 1'b0;
    md_class_dec = 1'b0;
    muldiv_dec   = 1'b0;
    hi_dec       = 1'b0;
    lo_dec       = 1'b0;
    case (instr_d_i[31:26])
      6'h00: begin
        case (instr_d_i[5:0])
          6'h00: begin op_dec = 5'd7;  reg_dst_dec = 2'b10; end
          6'h02: begin op_dec = 5'd9;  reg_dst_dec = 2'b10; end
          6'h03: begin op_dec = 5'd11; reg_dst_dec = 2'b10; end
          6'h04: begin op_dec = 5'd8;  reg_dst_dec = 2'b10; end
          6'h06: begin op_dec = 5'd10; reg_dst_dec = 2'b10; end
          6'h07: begin op_dec = 5'd12; reg_dst_dec = 2'b10; end
          6'h09: reg_dst_dec = 2'b10;
          6'h0A: begin op_dec = 5'd15; reg_dst_dec = 2'b10; end
          6'h10: begin op_dec = 5'd18; reg_dst_dec = 2'b10; md_class_dec = 1'b1; end
          6'h11: begin hi_dec = 1'b1; md_class_dec = 1'b1; end
          6'h12: begin op_dec = 5'd19; reg_dst_dec = 2'b10; md_class_dec = 1'b1; end
          6'h13: begin lo_dec = 1'b1; md_class_dec = 1'b1; end
          6'h18, 6'h19, 6'h1A, 6'h1B: begin muldiv_dec = 1'b1; md_class_dec = 1'b1; end
          6'h20, 6'h21: begin op_dec = 5'd5;  reg_dst_dec = 2'b10; end
          6'h22, 6'h23: begin op_dec = 5'd6;  reg_dst_dec = 2'b10; end
          6'h24: begin op_dec = 5'd1;  reg_dst_dec = 2'b10; end
          6'h25: begin op_dec = 5'd2;  reg_dst_dec = 2'b10; end
          6'h26: begin op_dec = 5'd3;  reg_dst_dec = 2'b10; end
          6'h27: begin op_dec = 5'd4;  reg_dst_dec = 2'b10; end
          6'h2A: begin op_dec = 5'd13; reg_dst_dec = 2'b10; end
          6'h2B: begin op_dec = 5'd14; reg_dst_dec = 2'b10; end
          default: ;
        endcase
      end
      // bltzal / bgezal link into $31
      6'h01: if (instr_d_i[20:17] == 4'b1000) reg_dst_dec = 2'b11;
      6'h03: reg_dst_dec = 2'b11;
      6'h08, 6'h09: begin op_dec = 5'd5;  reg_dst_dec = 2'b01; alu_src_dec = 1'b1; end
      6'h0A: begin op_dec = 5'd13; reg_dst_dec = 2'b01; alu_src_dec = 1'b1; end
      6'h0B: begin op_dec = 5'd14; reg_dst_dec = 2'b01; alu_src_dec = 1'b1; end
      6'h0C: begin op_dec = 5'd1;  reg_dst_dec = 2'b01; alu_src_dec = 1'b1; end
      6'h0D: begin op_dec = 5'd2;  reg_dst_dec = 2'b01; alu_src_dec = 1'b1; end
      6'h0E: begin op_dec = 5'd3;  reg_dst_dec = 2'b01; alu_src_dec = 1'b1; end
      // SPECIAL3 BSHFL: sa selects seb (0x10) or seh (0x18)
      6'h1F: begin
        if (instr_d_i[5:0] == 6'h20 && instr_d_i[10:6] == 5'h10) begin
          op_dec = 5'd17; reg_dst_dec = 2'b10;
        end else if (instr_d_i[5:0] == 6'h20 && instr_d_i[10:6] == 5'h18) begin
          op_dec = 5'd16; reg_dst_dec = 2'b10;
        end
      end
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: begin
        op_dec = 5'd5; reg_dst_dec = 2'b01; alu_src_dec = 1'b1;
      end
      6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: begin op_dec = 5'd5; alu_src_dec = 1'b1; end
      default: ;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy       = (state_q == StBusy) && !start_q;
    md_busy_o  = busy;
    md_start_o = start_q;
    md_done_o  = done_q;
    md_op_o    = md_op_q;
    stall_d_o  = (start_q | busy) & md_class_dec;
  end

  assign load_bubble = bubble_e_i | stall_d_o;
  assign issue       = !load_bubble && muldiv_dec && (state_q == StIdle);

  // FSM next state; the counter holds during the start cycle so busy lasts the full count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    start_d = issue;
    md_op_d = issue ? instr_d_i[1:0] : 2'b00;
    case (state_q)
      StIdle: begin
        if (issue) begin
          state_d = StBusy;
          cnt_d   = instr_d_i[1] ? DivLoad : MultLoad;
        end
      end
      StBusy: begin
        if (cancel) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (start_q) begin
          cnt_d = cnt_q;
        end else if (cnt_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      start_q <= 1'b0;
      md_op_q <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      md_op_q <= md_op_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      instr_e_q <= '0;
      alu_src_q <= 1'b0;
      reg_dst_q <= 2'b00;
      op_q      <= 5'd0;
      hi_we_q   <= 1'b0;
      lo_we_q   <= 1'b0;
    end else if (load_bubble) begin
      instr_e_q <= '0;
      alu_src_q <= 1'b0;
      reg_dst_q <= 2'b00;
      op_q      <= 5'd0;
      hi_we_q   <= 1'b0;
      lo_we_q   <= 1'b0;
    end else begin
      instr_e_q <= instr_d_i;
      alu_src_q <= alu_src_dec;
      reg_dst_q <= reg_dst_dec;
      op_q      <= op_dec;
      hi_we_q   <= hi_dec;
      lo_we_q   <= lo_dec;
    end
  end

  assign instr_e_o  = instr_e_q;
  assign alu_src_o  = alu_src_q;
  assign reg_dst_o  = reg_dst_q;
  assign operator_o = OP_W'(op_q);
  assign hi_we_o    = hi_we_q;
  assign lo_we_o    = lo_we_q;

endmodule
